// File: rtl/zorro_autoconfig_chain_if.sv
// Zorro II AUTOCONFIG bus bundle shared by the CPU side and the board chain.
// master: the CPU / bus driver. slave: the AUTOCONFIG chain.
interface zorro_autoconfig_chain_if #(
    parameter int NUM_BOARDS = 3
);
    logic                         CPU_AS;
    logic                         UDS;
    logic                         LDS;
    logic                         RW;
    logic [23:1]                  ADDRESS;
    logic [3:0]                   DATA_IN;
    logic [3:0]                   DATA_OUT;
    logic                         DATA_OE;
    logic                         CFG_DTACK;
    logic [NUM_BOARDS-1:0]        BOARD_SEL;
    logic [NUM_BOARDS-1:0]        CONFIGURED;
    logic [NUM_BOARDS-1:0][7:0]   BASE_ADDR;

    modport master (
        output CPU_AS, UDS, LDS, RW, ADDRESS, DATA_IN,
        input  DATA_OUT, DATA_OE, CFG_DTACK, BOARD_SEL, CONFIGURED, BASE_ADDR
    );

    modport slave (
        input  CPU_AS, UDS, LDS, RW, ADDRESS, DATA_IN,
        output DATA_OUT, DATA_OE, CFG_DTACK, BOARD_SEL, CONFIGURED, BASE_ADDR
    );
endinterface

// File: rtl/zorro_autoconfig_chain.sv
// Chain of NUM_BOARDS Zorro II AUTOCONFIG boards answering in the E8xxxx space.
// Only the lowest unconfigured, non-shut-up board answers; once a board is
// given its base address it decodes its own window through BOARD_SEL.
module zorro_autoconfig_chain #(
    parameter int                      NUM_BOARDS = 3,
    parameter logic [NUM_BOARDS*8-1:0] ER_TYPE    = {8'hC1, 8'hC1, 8'hE5},
    parameter logic [NUM_BOARDS*8-1:0] PRODUCT    = {8'h6A, 8'h69, 8'h68},
    parameter logic [15:0]             MFG_ID     = 16'h07DB,
    parameter logic [31:0]             SERIAL     = 32'h0000_0000,
    parameter int                      DTACK_WAIT = 1
) (
    input logic                     CPU_CLK,
    input logic                     RESET,
    zorro_autoconfig_chain_if.slave bus
);

    localparam logic [7:0] CFG_SPACE   = 8'hE8;
    localparam logic [6:0] OFF_BASE_HI = 7'h24;
    localparam logic [6:0] OFF_BASE_LO = 7'h25;
    localparam logic [6:0] OFF_SHUTUP  = 7'h26;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK,
        WAIT_END
    } state_t;

    // Registered state
    state_t                     state;
    logic [2:0]                 wait_cnt;
    logic                       armed;        // CPU_AS seen high since the last cycle start
    logic [3:0]                 pending;      // low nibble of the next base address
    logic [NUM_BOARDS-1:0]      configured_q;
    logic [NUM_BOARDS-1:0]      shutup_q;
    logic [NUM_BOARDS-1:0][7:0] base_q;
    logic                       dtack_n_q;
    logic                       data_oe_q;
    logic [3:0]                 data_out_q;

    // Combinational decode
    logic [1:0]                 idx;
    logic                       done;
    logic [7:0]                 sel_er;
    logic [7:0]                 sel_prod;
    logic [6:0]                 offset;
    logic                       ds_low;
    logic                       in_range;
    logic                       start;
    logic [3:0]                 rd_nibble;
    logic [15:0]                mfg_sh;
    logic [31:0]                ser_sh;
    logic [2:0]                 ser_nib;
    logic [NUM_BOARDS-1:0]      board_sel;
    logic                       unused_addr;

    // Size code -> A[23:16] compare mask. Code 0 means 8 MB (128 x 64 KB).
    function automatic logic [7:0] size_mask(input logic [2:0] code);
        logic [7:0] units;
        units = (code == 3'd0) ? 8'd128 : (8'd1 << (code - 3'd1));
        return ~(units - 8'd1);
    endfunction

    assign offset      = bus.ADDRESS[7:1];
    assign ds_low      = !(bus.UDS && bus.LDS);
    assign in_range    = (bus.ADDRESS[23:16] == CFG_SPACE) && !bus.CPU_AS && !done;
    assign start       = (state == IDLE) && armed && in_range && ds_low;
    assign unused_addr = ^bus.ADDRESS[15:8];

    // Pick the active board: lowest index neither configured nor shut up.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        done     = 1'b1;
        idx      = 2'd0;
        sel_er   = ER_TYPE[7:0];
        sel_prod = PRODUCT[7:0];
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (!configured_q[i] && !shutup_q[i]) begin
                done = 1'b0;
                idx  = 2'(i);
            end
        end
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (2'(i) == idx) begin
                sel_er   = ER_TYPE[i*8 +: 8];
                sel_prod = PRODUCT[i*8 +: 8];
            end
        end
    end

    // AUTOCONFIG ROM nibble for the current offset; everything but er_type is inverted.
    always_comb begin
        mfg_sh    = MFG_ID << {offset[1:0], 2'b00};
        // 0x0C..0x13 maps to nibble 0..7: the 3-bit subtraction wraps 0x10..0x13 onto 4..7.
        ser_nib   = offset[2:0] - 3'd4;
        ser_sh    = SERIAL << {ser_nib, 2'b00};
        rd_nibble = 4'hF;
        if (offset == 7'h00)
            rd_nibble = sel_er[7:4];
        else if (offset == 7'h01)
            rd_nibble = sel_er[3:0];
        else if (offset == 7'h02)
            rd_nibble = ~sel_prod[7:4];
        else if (offset == 7'h03)
            rd_nibble = ~sel_prod[3:0];
        else if (offset inside {7'h04, 7'h05})
            rd_nibble = ~4'h0;
        else if (offset inside {[7'h08:7'h0B]})
            rd_nibble = ~mfg_sh[15:12];
        else if (offset inside {[7'h0C:7'h13]})
            rd_nibble = ~ser_sh[31:28];
        else if (offset inside {7'h20, 7'h21})
            rd_nibble = 4'h0;
    end

    // Per-board window decode for configured boards, masked to the board size.
    always_comb begin
        board_sel = '0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            board_sel[i] = configured_q[i] && !bus.CPU_AS &&
                           ((bus.ADDRESS[23:16] & size_mask(ER_TYPE[i*8 +: 3])) ==
                            (base_q[i]          & size_mask(ER_TYPE[i*8 +: 3])));
        end
    end

    // Bus-cycle FSM with registered DTACK/OE/data; config writes land on cycle start.
    always_ff @(posedge CPU_CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            wait_cnt     <= 3'd0;
            armed        <= 1'b0;
            pending      <= 4'h0;
            configured_q <= '0;
            shutup_q     <= '0;
            // NOTE: base_q is a few flip-flops rather than a RAM, so it shares the async reset.
            base_q       <= '0;
            dtack_n_q    <= 1'b1;
            data_oe_q    <= 1'b0;
            data_out_q   <= 4'hF;
        end else begin
            // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
            if (bus.CPU_AS)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        armed     <= 1'b0;
                        state     <= ACCESS;
                        wait_cnt  <= 3'd1;
                        data_oe_q <= bus.RW;
                        if (bus.RW) begin
                            data_out_q <= rd_nibble;
                        end else begin
                            if (offset == OFF_BASE_LO)
                                pending <= bus.DATA_IN;
                            for (int i = 0; i < NUM_BOARDS; i++) begin
                                if (2'(i) == idx) begin
                                    if (offset == OFF_BASE_HI) begin
                                        base_q[i]       <= {bus.DATA_IN, pending};
                                        configured_q[i] <= 1'b1;
                                    end
                                    if (offset == OFF_SHUTUP)
                                        shutup_q[i] <= 1'b1;
                                end
                            end
                        end
                    end
                end

                ACCESS: begin
                    if (bus.CPU_AS) begin
                        state     <= IDLE;
                        data_oe_q <= 1'b0;
                    end else if (wait_cnt == 3'(DTACK_WAIT)) begin
                        state     <= ACK;
                        dtack_n_q <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end

                ACK: begin
                    if (bus.CPU_AS) begin
                        state     <= IDLE;
                        dtack_n_q <= 1'b1;
                        data_oe_q <= 1'b0;
                    end else begin
                        state <= WAIT_END;
                    end
                end

                WAIT_END: begin
                    if (bus.CPU_AS) begin
                        state     <= IDLE;
                        dtack_n_q <= 1'b1;
                        data_oe_q <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    dtack_n_q <= 1'b1;
                    data_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DATA_OUT   = data_out_q;
    assign bus.DATA_OE    = data_oe_q;
    assign bus.CFG_DTACK  = dtack_n_q;
    assign bus.BOARD_SEL  = board_sel;
    assign bus.CONFIGURED = configured_q;
    assign bus.BASE_ADDR  = base_q;

endmodule

// File: tb/tb_zorro_autoconfig_chain.sv
// Self-checking bench: two chains (DTACK_WAIT 1 and 3) share one CPU bus;
// directed scenarios first, then random cycles against a behavioural model.
module tb_zorro_autoconfig_chain;

    localparam logic [6:0] OFF_HI   = 7'h24;
    localparam logic [6:0] OFF_LO   = 7'h25;
    localparam logic [6:0] OFF_SHUT = 7'h26;
    localparam logic [15:0] MFG     = 16'h07DB;
    localparam logic [31:0] SER     = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        as_n = 1'b1;
    logic        uds = 1'b1;
    logic        lds = 1'b1;
    logic        rw = 1'b1;
    logic [23:1] addr = '0;
    logic [3:0]  din = 4'h0;
    logic        en1 = 1'b1;
    logic        en3 = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    zorro_autoconfig_chain_if #(.NUM_BOARDS(3)) bus1 ();
    zorro_autoconfig_chain_if #(.NUM_BOARDS(3)) bus3 ();

    assign bus1.CPU_AS  = as_n | ~en1;
    assign bus1.UDS     = uds;
    assign bus1.LDS     = lds;
    assign bus1.RW      = rw;
    assign bus1.ADDRESS = addr;
    assign bus1.DATA_IN = din;
    assign bus3.CPU_AS  = as_n | ~en3;
    assign bus3.UDS     = uds;
    assign bus3.LDS     = lds;
    assign bus3.RW      = rw;
    assign bus3.ADDRESS = addr;
    assign bus3.DATA_IN = din;

    zorro_autoconfig_chain #(.DTACK_WAIT(1)) dut1 (.CPU_CLK(clk), .RESET(rst), .bus(bus1));
    zorro_autoconfig_chain #(.DTACK_WAIT(3)) dut3 (.CPU_CLK(clk), .RESET(rst), .bus(bus3));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    bit         m_cfg  [3];
    bit         m_shut [3];
    logic [7:0] m_base [3];
    logic [3:0] m_pend;

    function automatic logic [7:0] m_er(input int b);
        return (b == 0) ? 8'hE5 : 8'hC1;
    endfunction

    function automatic logic [7:0] m_prod(input int b);
        return 8'h68 + 8'(b);
    endfunction

    function automatic int m_active();
        for (int i = 0; i < 3; i++)
            if (!m_cfg[i] && !m_shut[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] m_read(input int b, input int off);
        logic [7:0] er;
        logic [7:0] pr;
        er = m_er(b);
        pr = m_prod(b);
        if (off == 0) return er[7:4];
        if (off == 1) return er[3:0];
        if (off == 2) return ~pr[7:4];
        if (off == 3) return ~pr[3:0];
        if (off == 4 || off == 5) return 4'hF;
        if (off >= 8 && off <= 11) return ~4'((MFG >> (4 * (11 - off))) & 16'hF);
        if (off >= 12 && off <= 19) return ~4'((SER >> (4 * (19 - off))) & 32'hF);
        if (off == 32 || off == 33) return 4'h0;
        return 4'hF;
    endfunction

    function automatic logic [2:0] m_sel(input logic [7:0] hi);
        logic [2:0] r;
        int units;
        int code;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            code  = int'(m_er(i) & 8'h07);
            units = (code == 0) ? 128 : (1 << (code - 1));
            r[i]  = m_cfg[i] && ((int'(hi) / units) == (int'(m_base[i]) / units));
        end
        return r;
    endfunction

    function automatic logic [2:0] m_cfg_vec();
        return {m_cfg[2], m_cfg[1], m_cfg[0]};
    endfunction

    function automatic logic [23:0] m_base_vec();
        return {m_base[2], m_base[1], m_base[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cfg[i]  = 1'b0;
            m_shut[i] = 1'b0;
            m_base[i] = 8'h00;
        end
        m_pend = 4'h0;
    endtask

    // ---------------- bus driving ----------------
    int         lat1, lat3;
    logic [3:0] rd1, rd3;
    logic       oe1, oe3, rel1, rel3;

    task automatic apply_reset();
        rst  = 1'b1;
        as_n = 1'b1;
        uds  = 1'b1;
        lds  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dtack"}, 32'(bus1.CFG_DTACK), 32'd1);
        check({tag, "_oe"},    32'(bus1.DATA_OE), 32'd0);
        check({tag, "_dout"},  32'(bus1.DATA_OUT), 32'hF);
        check({tag, "_sel"},   32'(bus1.BOARD_SEL), 32'd0);
        check({tag, "_cfg"},   32'(bus1.CONFIGURED), 32'd0);
        check({tag, "_base"},  32'(bus1.BASE_ADDR), 32'd0);
        check({tag, "_dtack3"}, 32'(bus3.CFG_DTACK), 32'd1);
        check({tag, "_cfg3"},  32'(bus3.CONFIGURED), 32'd0);
    endtask

    // One full E8 cycle on the shared bus; measures DTACK latency per chain.
    task automatic run_cycle(input logic r, input logic [6:0] off, input logic [3:0] d, input int limit);
        @(negedge clk);
        addr = {8'hE8, 8'h00, off};
        rw   = r;
        din  = d;
        as_n = 1'b0;
        uds  = 1'b0;
        lds  = 1'b0;
        lat1 = 0;
        lat3 = 0;
        oe1  = 1'b0;
        oe3  = 1'b0;
        rd1  = 4'h0;
        rd3  = 4'h0;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (bus1.DATA_OE) oe1 = 1'b1;
            if (bus3.DATA_OE) oe3 = 1'b1;
            if (lat1 == 0 && !bus1.CFG_DTACK) begin lat1 = n; rd1 = bus1.DATA_OUT; end
            if (lat3 == 0 && !bus3.CFG_DTACK) begin lat3 = n; rd3 = bus3.DATA_OUT; end
            if (lat1 != 0 && lat3 != 0) break;
        end
        as_n = 1'b1;
        uds  = 1'b1;
        lds  = 1'b1;
        @(negedge clk);
        rel1 = bus1.CFG_DTACK;
        rel3 = bus3.CFG_DTACK;
    endtask

    task automatic do_read(input logic [6:0] off);
        int b;
        b = m_active();
        run_cycle(1'b1, off, 4'h0, 10);
        if (b < 0) begin
            check("done_rd_lat1", 32'(lat1), 32'd0);
            check("done_rd_lat3", 32'(lat3), 32'd0);
            check("done_rd_oe1", 32'(oe1), 32'd0);
            check("done_rd_oe3", 32'(oe3), 32'd0);
        end else begin
            check("rd_lat1", 32'(lat1), 32'd2);
            check("rd_lat3", 32'(lat3), 32'd4);
            check("rd_data1", 32'(rd1), 32'(m_read(b, int'(off))));
            check("rd_data3", 32'(rd3), 32'(m_read(b, int'(off))));
            check("rd_oe1", 32'(oe1), 32'd1);
            check("rd_oe3", 32'(oe3), 32'd1);
        end
        check("rel_dtack1", 32'(rel1), 32'd1);
        check("rel_dtack3", 32'(rel3), 32'd1);
    endtask

    task automatic do_write(input logic [6:0] off, input logic [3:0] d);
        int b;
        b = m_active();
        run_cycle(1'b0, off, d, 10);
        if (b >= 0) begin
            if (off == OFF_LO) m_pend = d;
            if (off == OFF_HI) begin m_base[b] = {d, m_pend}; m_cfg[b] = 1'b1; end
            if (off == OFF_SHUT) m_shut[b] = 1'b1;
            if (m_active() >= 0) begin
                check("wr_lat1", 32'(lat1), 32'd2);
                check("wr_lat3", 32'(lat3), 32'd4);
            end
        end else begin
            check("done_wr_lat1", 32'(lat1), 32'd0);
            check("done_wr_lat3", 32'(lat3), 32'd0);
        end
        check("wr_oe1", 32'(oe1), 32'd0);
        check("wr_cfg1", 32'(bus1.CONFIGURED), 32'(m_cfg_vec()));
        check("wr_cfg3", 32'(bus3.CONFIGURED), 32'(m_cfg_vec()));
        check("wr_base1", 32'(bus1.BASE_ADDR), 32'(m_base_vec()));
        check("wr_base3", 32'(bus3.BASE_ADDR), 32'(m_base_vec()));
    endtask

    // Address-only probe between edges: AS low, no data strobe, no clock edge crossed.
    task automatic probe_sel(input logic [7:0] hi);
        @(negedge clk);
        addr = {hi, 15'($urandom)};
        as_n = 1'b0;
        uds  = 1'b1;
        lds  = 1'b1;
        #1;
        check("board_sel1", 32'(bus1.BOARD_SEL), 32'(m_sel(hi)));
        check("board_sel3", 32'(bus3.BOARD_SEL), 32'(m_sel(hi)));
        as_n = 1'b1;
        #1;
        check("board_sel_as_hi", 32'(bus1.BOARD_SEL), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic saw_low;
        model_reset();
        #12;
        check_reset_vals("reset");
        apply_reset();

        // Defaults: er_type nibbles of board 0.
        do_read(7'h00);
        check("e8_0000", 32'(rd1), 32'hE);
        do_read(7'h01);
        check("e8_0002", 32'(rd1), 32'h5);
        do_read(7'h09);
        do_read(7'h21);

        // Configure board 0 at 0x20, then board 1 becomes active.
        do_write(OFF_LO, 4'h0);
        do_write(OFF_HI, 4'h2);
        check("base0_20", 32'(bus1.BASE_ADDR[0]), 32'h20);
        check("cfg_001", 32'(bus1.CONFIGURED), 32'b001);
        do_read(7'h00);
        check("board1_er", 32'(rd1), 32'hC);

        // Board 0 is a 1 MB board at 0x200000.
        probe_sel(8'h20);
        probe_sel(8'h2F);
        probe_sel(8'h30);
        probe_sel(8'h1F);
        check("sel_explicit_lo", 32'(m_sel(8'h2F)), 32'b001);

        // AS rises during ACCESS on the DTACK_WAIT=3 chain: no DTACK at all.
        en1 = 1'b0;
        @(negedge clk);
        addr = {8'hE8, 8'h00, 7'h00};
        rw   = 1'b1;
        as_n = 1'b0;
        uds  = 1'b0;
        lds  = 1'b0;
        saw_low = 1'b0;
        @(negedge clk);
        check("abort_oe_access", 32'(bus3.DATA_OE), 32'd1);
        if (!bus3.CFG_DTACK) saw_low = 1'b1;
        @(negedge clk);
        if (!bus3.CFG_DTACK) saw_low = 1'b1;
        as_n = 1'b1;
        uds  = 1'b1;
        lds  = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (!bus3.CFG_DTACK) saw_low = 1'b1;
        end
        check("abort_no_dtack", 32'(saw_low), 32'd0);
        check("abort_oe_idle", 32'(bus3.DATA_OE), 32'd0);
        en1 = 1'b1;
        do_read(7'h02);

        // Reset pulsed mid-cycle while both chains hold DTACK.
        @(negedge clk);
        addr = {8'hE8, 8'h00, 7'h00};
        rw   = 1'b1;
        as_n = 1'b0;
        uds  = 1'b0;
        lds  = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_dtack1", 32'(bus1.CFG_DTACK), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        #2 rst = 1'b0;
        saw_low = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (!bus1.CFG_DTACK || !bus3.CFG_DTACK || bus1.DATA_OE) saw_low = 1'b1;
        end
        check("post_rst_ignored", 32'(saw_low), 32'd0);
        as_n = 1'b1;
        uds  = 1'b1;
        lds  = 1'b1;
        model_reset();
        @(negedge clk);
        do_read(7'h00);
        check("board0_again", 32'(rd1), 32'hE);

        // Shut up every board: chain done, never responds.
        do_write(OFF_SHUT, 4'h0);
        do_write(OFF_SHUT, 4'h0);
        do_write(OFF_SHUT, 4'h0);
        check("shutup_cfg0", 32'(bus1.CONFIGURED), 32'd0);
        do_read(7'h00);
        do_write(OFF_HI, 4'h5);
        apply_reset();

        // Randomized traffic against the model.
        for (int it = 0; it < 160; it++) begin
            int         op;
            logic [6:0] off;
            logic [3:0] d;
            logic [7:0] hi;
            op = $urandom_range(0, 9);
            d  = 4'($urandom);
            if (m_active() < 0) begin
                do_read(7'($urandom));
                apply_reset();
            end else if (op <= 3) begin
                off = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 'h22)) : 7'($urandom);
                do_read(off);
            end else if (op == 4) begin
                do_write(OFF_LO, d);
            end else if (op == 5) begin
                do_write(OFF_HI, d);
            end else if (op == 6) begin
                if ($urandom_range(0, 2) == 0) begin
                    do_write(OFF_SHUT, d);
                end else begin
                    off = 7'($urandom);
                    if (off inside {OFF_HI, OFF_LO, OFF_SHUT}) off = 7'h27;
                    do_write(off, d);
                end
            end else begin
                if ($urandom_range(0, 1) == 0)
                    hi = m_base[$urandom_range(0, 2)] ^ 8'(1 << $urandom_range(0, 7));
                else
                    hi = 8'($urandom);
                probe_sel(hi);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/zorro_autoconfig_chain.md
ZORRO_AUTOCONFIG_CHAIN -- requirements
Module: zorro_autoconfig_chain

Interface
REQ-001 Parameter NUM_BOARDS, default 3: number of chained AUTOCONFIG boards, legal range 1..4.
REQ-002 Parameter ER_TYPE, default {8'hC1,8'hC1,8'hE5}: packed NUM_BOARDS x 8-bit er_type bytes, board 0 in bits [7:0].
REQ-003 Parameter PRODUCT, default {8'h6A,8'h69,8'h68}: packed NUM_BOARDS x 8-bit product numbers.
REQ-004 Parameter MFG_ID, default 16'h07DB: manufacturer number shared by all boards.
REQ-005 Parameter SERIAL, default 32'h0000_0000: serial number shared by all boards.
REQ-006 Parameter DTACK_WAIT, default 1: CPU_CLK cycles from ACCESS entry to CFG_DTACK assertion, legal range 1..7.
REQ-007 CPU_CLK  in  1  sole clock, rising edge active.
REQ-008 RESET  in  1  asynchronous, active-high reset.
REQ-009 CPU_AS  in  1  CPU address strobe, active low, synchronous to CPU_CLK.
REQ-010 UDS, LDS  in  1 each  data strobes, active low; DS = UDS AND LDS.
REQ-011 RW  in  1  1 = read, 0 = write.
REQ-012 ADDRESS  in  23  CPU address [23:1].
REQ-013 DATA_IN  in  4  CPU data [15:12] for writes.
REQ-014 DATA_OUT  out  4  AUTOCONFIG nibble for D[15:12].
REQ-015 DATA_OE  out  1  high drives DATA_OUT onto D[15:12].
REQ-016 CFG_DTACK  out  1  active-low DTACK for AUTOCONFIG cycles.
REQ-017 BOARD_SEL  out  NUM_BOARDS  per-board address hit, active high.
REQ-018 CONFIGURED  out  NUM_BOARDS  per-board configured flag.
REQ-019 BASE_ADDR  out  NUM_BOARDS x 8  per-board base address A[23:16].

Function
REQ-020 Active board idx SHALL be the lowest index whose configured and shutup bits are both clear; when no such index exists, the chain is DONE.
REQ-021 Range SHALL be ADDRESS[23:16]==8'hE8 with CPU_AS low and not DONE.
REQ-022 FSM states SHALL be IDLE, ACCESS, ACK and WAIT_END.
REQ-023 IDLE->ACCESS SHALL occur when range holds and DS is low at a clock edge.
REQ-024 ACCESS SHALL count DTACK_WAIT clocks, then go to ACK.
REQ-025 ACK SHALL go to WAIT_END, which SHALL hold until CPU_AS is sampled high, then go to IDLE.
REQ-026 CPU_AS sampled high in ACCESS or ACK SHALL force IDLE.
REQ-027 CFG_DTACK SHALL be low in ACK and WAIT_END only, and high within one clock of CPU_AS rising.
REQ-028 Each write SHALL take effect exactly once, on the IDLE->ACCESS transition.
REQ-029 Write to ADDRESS[7:1]=7'h25 SHALL latch DATA_IN into the pending low nibble.
REQ-030 Write to 7'h24 SHALL set BASE_ADDR[idx]={DATA_IN,pending} and CONFIGURED[idx]=1; the next board becomes active on the following cycle.
REQ-031 Write to 7'h26 SHALL set shutup[idx]=1 and leave CONFIGURED[idx]=0.
REQ-032 Writes to any other offset SHALL be ignored.
REQ-033 Reads SHALL register DATA_OUT on IDLE->ACCESS; DATA_OE SHALL be high from ACCESS through WAIT_END while RW=1.
REQ-034 Read data for offsets 7'h00/7'h01 SHALL be ER_TYPE[idx][7:4] and [3:0], not inverted.
REQ-035 Read data for 7'h02/7'h03 SHALL be inverted PRODUCT[idx] nibbles, high nibble first.
REQ-036 Read data for 7'h04/7'h05 SHALL be inverted 8'h00.
REQ-037 Read data for 7'h08..7'h0B SHALL be inverted MFG_ID nibbles, MSB first.
REQ-038 Read data for 7'h0C..7'h13 SHALL be inverted SERIAL nibbles, MSB first.
REQ-039 Read data for 7'h20/7'h21 SHALL be 4'h0; all other offsets SHALL read 4'hF.
REQ-040 Size in 64 KB units SHALL be 2^(code-1) for ER_TYPE[idx][2:0] code 1..7, and 128 (8 MB) for code 0.
REQ-041 BOARD_SEL[i] SHALL be combinational: CONFIGURED[i] AND CPU_AS low AND ADDRESS[23:16] masked by the size equals BASE_ADDR[i] under the same mask.
REQ-042 Base bits below the size alignment SHALL be ignored in the compare.
REQ-043 When DONE, the module SHALL never respond: DATA_OE=0 and CFG_DTACK=1.

Reset
REQ-044 RESET high SHALL asynchronously force FSM=IDLE, CFG_DTACK=1, DATA_OE=0, DATA_OUT=4'hF, BOARD_SEL=0, CONFIGURED=0, shutup=0, BASE_ADDR=0 and pending=0.
REQ-045 RESET asserted mid-cycle SHALL abort without a DTACK; a cycle still in progress at deassertion SHALL be ignored until CPU_AS is sampled high.

Verification
REQ-046 Defaults; read E8_0000 and E8_0002 -> DATA_OUT 4'hE then 4'h5; CFG_DTACK low 1 clock after ACCESS; high 1 clock after CPU_AS rises.
REQ-047 Write 4'h0 to offset 25 then 4'h2 to offset 24 -> BASE_ADDR[0]=8'h20, CONFIGURED=3'b001; next E8_0000 read returns 4'hC (board 1).
REQ-048 Board 0 ER_TYPE code 5 at base 8'h20 -> BOARD_SEL[0] high for 0x200000..0x2FFFFF, low at 0x300000 and 0x1FFFFF.
REQ-049 Write offset 26 to all three boards -> CONFIGURED=0; subsequent E8 cycles get no DTACK and DATA_OE=0.
REQ-050 CPU_AS rises during ACCESS with DTACK_WAIT=3 -> CFG_DTACK never asserts, FSM returns IDLE.
REQ-051 RESET pulsed during WAIT_END after board 0 is configured -> all outputs at reset values; board 0 is active again.
